rtc_read_capture: RTL and testbench



---
 rtl/rtc_read_capture_pkg.sv | 39 +++
 rtl/rtc_read_capture_bcd_range_check.sv | 17 +
 rtl/rtc_read_capture.sv | 136 +++++++++++++
 tb/tb_rtc_read_capture.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_read_capture_pkg.sv
// Shared definitions for the RTC read path: FSM states, error codes and per-field BCD limits.
// The field limits are also meant for the display and write paths.
package rtc_read_capture_pkg;

   localparam int unsigned N_REGS = 6;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StCheck = 2'd2,
      StDone  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ErrNone    = 2'd0,
      ErrNibble  = 2'd1,
      ErrRange   = 2'd2,
      ErrTimeout = 2'd3
   } err_code_t;

   // Field order: seg, min, hora, dia, mes, anio.
   function automatic logic [7:0] field_min(input logic [2:0] fld);
      case (fld)
         3'd3, 3'd4: return 8'h01;
         default:    return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] field_max(input logic [2:0] fld);
      case (fld)
         3'd0, 3'd1: return 8'h59;
         3'd2:       return 8'h23;
         3'd3:       return 8'h31;
         3'd4:       return 8'h12;
         default:    return 8'h99;
      endcase
   endfunction

endpackage

// File: rtl/rtc_read_capture_bcd_range_check.sv
// Combinational validity check of one BCD byte against the limits of its field.
// Range compare is done on the raw byte, which is only meaningful once both nibbles are decimal.
module rtc_read_capture_bcd_range_check
   import rtc_read_capture_pkg::*;
(
   input  logic [7:0] data,
   input  logic [2:0] fld,
   output logic       nib_err,
   output logic       rng_err
);

   always_comb begin
      nib_err = (data[7:4] > 4'd9) || (data[3:0] > 4'd9);
      rng_err = (data < field_min(fld)) || (data > field_max(fld));
   end

endmodule

// File: rtl/rtc_read_capture.sv
// Burst reader for the six RTC time/date registers: handshakes each byte, validates it,
// and commits all fields atomically on success or flags an error and keeps the old values.
module rtc_read_capture
   import rtc_read_capture_pkg::*;
#(
   parameter logic [5:0]  REF_BASE = 6'd16,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic [7:0] Dato_in,
   input  logic       Dato_valid,
   output logic [5:0] Ref,
   output logic       Rd_req,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [1:0] Err_code,
   output logic [7:0] Seg,
   output logic [7:0] Min,
   output logic [7:0] Hora,
   output logic [7:0] Dia,
   output logic [7:0] Mes,
   output logic [7:0] Anio
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_t        state;
   logic [2:0]    idx;
   logic [TW-1:0] tcount;
   logic [7:0]    shadow_byte;
   // Last field is committed straight from shadow_byte, so the bank holds only the first five.
   logic [7:0]    bank [N_REGS-1];
   logic          nib_err;
   logic          rng_err;

   rtc_read_capture_bcd_range_check u_check (
      .data    (shadow_byte),
      .fld     (idx),
      .nib_err (nib_err),
      .rng_err (rng_err)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= StIdle;
         idx         <= '0;
         tcount      <= '0;
         shadow_byte <= 8'h00;
         for (int i = 0; i < N_REGS - 1; i++) bank[i] <= 8'h00;
         Ref         <= '0;
         Rd_req      <= 1'b0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Err         <= 1'b0;
         Err_code    <= ErrNone;
         Seg         <= 8'h00;
         Min         <= 8'h00;
         Hora        <= 8'h00;
         Dia         <= 8'h01;
         Mes         <= 8'h01;
         Anio        <= 8'h00;
      end else begin
         case (state)
            StIdle: begin
               if (Start) begin
                  state    <= StReq;
                  idx      <= '0;
                  tcount   <= '0;
                  Err      <= 1'b0;
                  Err_code <= ErrNone;
                  Busy     <= 1'b1;
                  Rd_req   <= 1'b1;
                  Ref      <= REF_BASE;
               end
            end

            StReq: begin
               // A capture on the final timeout cycle takes priority over the timeout.
               if (Dato_valid) begin
                  shadow_byte <= Dato_in;
                  Rd_req      <= 1'b0;
                  state       <= StCheck;
               end else if (tcount == TW'(TIMEOUT - 1)) begin
                  Err      <= 1'b1;
                  Err_code <= ErrTimeout;
                  Rd_req   <= 1'b0;
                  Ref      <= '0;
                  Done     <= 1'b1;
                  state    <= StDone;
               end else begin
                  tcount <= tcount + 1'b1;
               end
            end

            StCheck: begin
               if (nib_err || rng_err) begin
                  Err      <= 1'b1;
                  Err_code <= nib_err ? ErrNibble : ErrRange;
                  Ref      <= '0;
                  Done     <= 1'b1;
                  state    <= StDone;
               end else if (idx == 3'(N_REGS - 1)) begin
                  Seg   <= bank[0];
                  Min   <= bank[1];
                  Hora  <= bank[2];
                  Dia   <= bank[3];
                  Mes   <= bank[4];
                  Anio  <= shadow_byte;
                  Ref   <= '0;
                  Done  <= 1'b1;
                  state <= StDone;
               end else begin
                  bank[idx] <= shadow_byte;
                  idx       <= idx + 3'd1;
                  tcount    <= '0;
                  Ref       <= REF_BASE + {3'b000, idx} + 6'd1;
                  Rd_req    <= 1'b1;
                  state     <= StReq;
               end
            end

            StDone: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= StIdle;
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_read_capture.sv
// Randomised bench for rtc_read_capture: a bus-controller driver feeds bytes, a decimal-level
// model predicts each burst's outcome, and a monitor checks it whenever Done pulses.
module tb_rtc_read_capture;

   localparam int TIMEOUT = 255;

   typedef struct packed {
      logic        err;
      logic [1:0]  code;
      logic [47:0] flds;
      logic [15:0] lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic       dvalid;
   logic [5:0] ref_o;
   logic       rd_req;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] code_o;
   logic [7:0] seg, min, hora, dia, mes, anio;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   logic [7:0] m_f   [6];
   logic [7:0] cur_b [6];
   int         cur_w [6];
   int         fmin  [6] = '{0, 0, 0, 1, 1, 0};
   int         fmax  [6] = '{59, 59, 23, 31, 12, 99};

   rtc_read_capture dut (
      .Clock      (clk),
      .Reset      (rst),
      .Start      (start),
      .Dato_in    (din),
      .Dato_valid (dvalid),
      .Ref        (ref_o),
      .Rd_req     (rd_req),
      .Busy       (busy),
      .Done       (done),
      .Err        (err),
      .Err_code   (code_o),
      .Seg        (seg),
      .Min        (min),
      .Hora       (hora),
      .Dia        (dia),
      .Mes        (mes),
      .Anio       (anio)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int d);
      return 8'((d / 10) * 16 + (d % 10));
   endfunction

   // 0 ok, 1 non-decimal digit, 2 decimal value outside the field's calendar range.
   function automatic int ref_code(input int fld, input logic [7:0] b);
      int hi = int'(b) / 16;
      int lo = int'(b) % 16;
      int v;
      if (hi > 9 || lo > 9) return 1;
      v = hi * 10 + lo;
      if (v < fmin[fld] || v > fmax[fld]) return 2;
      return 0;
   endfunction

   function automatic logic [47:0] model_flds();
      return {m_f[5], m_f[4], m_f[3], m_f[2], m_f[1], m_f[0]};
   endfunction

   task automatic model_reset();
      m_f = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ref"}, ref_o, 0);
      chk({tag, "_rd_req"}, rd_req, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_code"}, code_o, 0);
      chk({tag, "_fields"}, {anio, mes, dia, hora, min, seg}, 48'h00_01_01_00_00_00);
   endtask

   // Wait for the read request of byte i, check Ref, then answer after cur_w[i] idle cycles.
   task automatic drive_byte(input int i, input bit sb, input bit answer, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!rd_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!rd_req) begin
         checks++;
         errors++;
         $display("FAIL rd_req_wait: byte %0d request not seen within 8 cycles", i);
         return;
      end
      chk("ref", ref_o, 64'(16 + i));
      ok = 1'b1;
      if (!answer) return;
      for (int k = 0; k < cur_w[i]; k++) begin
         start = sb;
         @(negedge clk);
      end
      start  = 1'b0;
      dvalid = 1'b1;
      din    = cur_b[i];
      @(negedge clk);
      dvalid = 1'b0;
      din    = 8'($urandom);
   endtask

   task automatic run_burst(input bit sb);
      exp_t       e;
      int         lat  = 0;
      int         last = 5;
      int         c    = 0;
      bit         to   = 1'b0;
      bit         ok;
      int         n    = 0;
      for (int i = 0; i < 6; i++) begin
         if (cur_w[i] >= TIMEOUT) begin
            lat += TIMEOUT;
            c = 3;
            last = i;
            to = 1'b1;
            break;
         end
         lat += 2 + cur_w[i];
         c = ref_code(i, cur_b[i]);
         if (c != 0) begin
            last = i;
            break;
         end
      end
      if (c == 0) for (int i = 0; i < 6; i++) m_f[i] = cur_b[i];
      e.err  = (c != 0);
      e.code = 2'(c);
      e.flds = model_flds();
      e.lat  = 16'(lat);
      sb_q.push_back(e);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("err_cleared", err, 0);
      chk("code_cleared", code_o, 0);
      for (int i = 0; i <= last; i++) begin
         drive_byte(i, sb, !(to && i == last), ok);
         if (!ok) break;
      end
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL burst_end: busy still 1 after 1000 cycles");
      end
      @(negedge clk);
   endtask

   task automatic load_valid(input int w);
      for (int i = 0; i < 6; i++) begin
         cur_b[i] = to_bcd(fmax[i]);
         cur_w[i] = w;
      end
   endtask

   // Monitor: measures burst length from the first Busy cycle and checks each Done.
   initial begin : monitor
      int   mcnt = 0;
      bit   in_burst = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_burst = 1'b0;
         end else begin
            if (busy && !in_burst) begin
               in_burst = 1'b1;
               mcnt = 0;
            end else if (in_burst) begin
               mcnt++;
            end
            if (done) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: Done=1 with no burst outstanding");
               end else begin
                  e = sb_q.pop_front();
                  chk("done_err", err, e.err);
                  chk("done_code", code_o, e.code);
                  chk("done_fields", {anio, mes, dia, hora, min, seg}, e.flds);
                  chk("done_latency", 64'(mcnt), e.lat);
                  chk("done_rd_req", rd_req, 0);
                  chk("done_ref", ref_o, 0);
               end
            end
            if (!busy) in_burst = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit ok;
      int n;
      rst    = 1'b1;
      start  = 1'b0;
      dvalid = 1'b0;
      din    = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset("in_reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset("after_reset");

      // Happy path with data held valid at once.
      cur_b = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};
      cur_w = '{0, 0, 0, 0, 0, 0};
      run_burst(1'b0);

      // Invalid nibble on hora.
      cur_b = '{8'h10, 8'h11, 8'h2A, 8'h05, 8'h06, 8'h07};
      run_burst(1'b0);

      // Range errors on hora, dia and mes.
      cur_b = '{8'h00, 8'h00, 8'h24, 8'h01, 8'h01, 8'h00};
      run_burst(1'b0);
      cur_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      run_burst(1'b0);
      cur_b = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h13, 8'h00};
      run_burst(1'b0);

      // Timeout on the first byte, then a burst that clears Err.
      load_valid(0);
      cur_w[0] = TIMEOUT;
      run_burst(1'b0);
      cur_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      cur_w = '{0, 0, 0, 0, 0, 0};
      run_burst(1'b0);

      // Capture on the last permitted REQ cycle, then one cycle too late.
      load_valid(1);
      cur_b[0] = 8'h42;
      cur_w[0] = TIMEOUT - 1;
      run_burst(1'b0);
      load_valid(0);
      cur_w[3] = TIMEOUT;
      run_burst(1'b0);

      // Start held high while busy must not restart or extend the burst.
      load_valid(3);
      cur_b[5] = 8'h24;
      run_burst(1'b1);
      repeat (3) @(negedge clk);
      chk("start_while_busy_idle", busy, 0);

      // Randomised bursts.
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 6; i++) begin
            cur_w[i] = $urandom_range(0, 10);
            if ($urandom_range(0, 15) == 0) cur_b[i] = 8'($urandom);
            else cur_b[i] = to_bcd($urandom_range(fmin[i], fmax[i]));
         end
         run_burst(1'b0);
      end

      // Reset during byte 3's request: no Done, no partial commit.
      load_valid(0);
      cur_b[3] = 8'h15;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) drive_byte(i, 1'b0, 1'b1, ok);
      drive_byte(3, 1'b0, 1'b0, ok);
      rst = 1'b1;
      #1;
      model_reset();
      check_reset("mid_burst_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset("after_mid_reset");

      cur_b = '{8'h30, 8'h45, 8'h12, 8'h28, 8'h02, 8'h24};
      cur_w = '{1, 0, 2, 0, 3, 0};
      run_burst(1'b0);

      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 64'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
